// File: rtl/zapper_flash_seq.sv
// zapper_flash_seq: light-gun hit-detection flash sequencer.
//
// A trigger press draws one all-black frame, then one frame per enabled target in which
// only that target's box is white. The photodiode is sampled every frame. Light during
// the black frame marks the shot as a cheat. The first target frame that sees light is
// recorded as the hit. The result is strobed once, when the last frame ends.
//
// Ports:
//   clk, rst         pixel clock, asynchronous active-high reset
//   frame_start      one-cycle strobe at the first vblank cycle of each frame
//   valid, col, row  active-video qualifier and current pixel position
//   bg_rgb           colour from the sprite generator
//   trigger, light   synchronised gun trigger (level) and photodiode
//   target_en/x/y    per-target enable and box top-left corner, 10 bits per target
//   rgb              registered pixel colour to the DAC
//   busy             high while a flash sequence or its hold is in progress
//   hit_valid        one-cycle result strobe
//   hit, hit_idx     result, held until the next strobe
module zapper_flash_seq #(
  parameter int unsigned N_TARGETS = 2,
  parameter int unsigned BOX_W     = 32,
  parameter int unsigned BOX_H     = 32,
  parameter int unsigned RGB_W     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic                    valid,
  input  logic [9:0]              col,
  input  logic [9:0]              row,
  input  logic [RGB_W-1:0]        bg_rgb,
  input  logic                    trigger,
  input  logic                    light,
  input  logic [N_TARGETS-1:0]    target_en,
  input  logic [10*N_TARGETS-1:0] target_x,
  input  logic [10*N_TARGETS-1:0] target_y,
  output logic [RGB_W-1:0]        rgb,
  output logic                    busy,
  output logic                    hit_valid,
  output logic                    hit,
  output logic [1:0]              hit_idx
);

  typedef enum logic [1:0] {StIdle, StBlack, StTgt, StHeld} state_e;

  state_e           state_q, state_d;
  logic [1:0]       k_q, k_d;
  logic             pending_q, pending_d;
  logic             cheat_q, cheat_d;
  logic             shit_q, shit_d;
  logic [1:0]       sidx_q, sidx_d;
  logic             trig_q;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hv_q, hv_d;
  logic             hit_q, hit_d;
  logic [1:0]       hit_idx_q, hit_idx_d;

  logic       rise;
  logic       finish;
  logic       first_found, next_found;
  logic [1:0] first_idx, next_idx;
  logic [9:0] cur_x, cur_y;
  logic       in_box;

  assign rise = trigger & ~trig_q;

  // Lowest enabled target overall, lowest enabled target above k_q, and the box of k_q.
  // The loop runs downwards so the last match is the lowest index.
  always_comb begin
    first_found = 1'b0;
    first_idx   = 2'd0;
    next_found  = 1'b0;
    next_idx    = 2'd0;
    cur_x       = 10'd0;
    cur_y       = 10'd0;
    for (int i = int'(N_TARGETS) - 1; i >= 0; i--) begin
      if (target_en[i]) begin
        first_found = 1'b1;
        first_idx   = 2'(i);
        if (2'(i) > k_q) begin
          next_found = 1'b1;
          next_idx   = 2'(i);
        end
      end
      if (2'(i) == k_q) begin
        cur_x = target_x[10*i +: 10];
        cur_y = target_y[10*i +: 10];
      end
    end
  end

  // 11-bit compare so a box starting near 1023 never wraps onto low columns.
  assign in_box = ({1'b0, col} >= {1'b0, cur_x}) &&
                  ({1'b0, col} <  {1'b0, cur_x} + 11'(BOX_W)) &&
                  ({1'b0, row} >= {1'b0, cur_y}) &&
                  ({1'b0, row} <  {1'b0, cur_y} + 11'(BOX_H));

  always_comb begin
    rgb_d = '0;
    if (valid) begin
      unique case (state_q)
        StIdle, StHeld: rgb_d = bg_rgb;
        StBlack:        rgb_d = '0;
        StTgt:          rgb_d = in_box ? '1 : '0;
        default:        rgb_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    pending_d = pending_q;
    cheat_d   = cheat_q;
    shit_d    = shit_q;
    sidx_d    = sidx_q;
    hv_d      = 1'b0;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    finish    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rise) pending_d = 1'b1;
        if (frame_start && (pending_q || rise)) begin
          state_d   = StBlack;
          pending_d = 1'b0;
          cheat_d   = 1'b0;
          shit_d    = 1'b0;
          sidx_d    = 2'd0;
        end
      end
      StBlack: begin
        if (valid && light) cheat_d = 1'b1;
        if (frame_start) begin
          if (first_found) begin
            state_d = StTgt;
            k_d     = first_idx;
          end else begin
            finish = 1'b1;
          end
        end
      end
      StTgt: begin
        // First hit wins; later frames seeing light do not overwrite it.
        if (valid && light && !shit_q) begin
          shit_d = 1'b1;
          sidx_d = k_q;
        end
        if (frame_start) begin
          if (next_found) k_d = next_idx;
          else            finish = 1'b1;
        end
      end
      StHeld: begin
        if (frame_start && !trigger) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // The _d scratch values include a light sample taken in this frame_start cycle.
    if (finish) begin
      state_d   = StHeld;
      hv_d      = 1'b1;
      hit_d     = shit_d & ~cheat_d;
      hit_idx_d = (shit_d & ~cheat_d) ? sidx_d : 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      k_q       <= 2'd0;
      pending_q <= 1'b0;
      cheat_q   <= 1'b0;
      shit_q    <= 1'b0;
      sidx_q    <= 2'd0;
      trig_q    <= 1'b0;
      rgb_q     <= '0;
      hv_q      <= 1'b0;
      hit_q     <= 1'b0;
      hit_idx_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      pending_q <= pending_d;
      cheat_q   <= cheat_d;
      shit_q    <= shit_d;
      sidx_q    <= sidx_d;
      trig_q    <= trigger;
      rgb_q     <= rgb_d;
      hv_q      <= hv_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
    end
  end

  assign rgb       = rgb_q;
  assign busy      = (state_q != StIdle);
  assign hit_valid = hv_q;
  assign hit       = hit_q;
  assign hit_idx   = hit_idx_q;

endmodule

// File: tb/tb_zapper_flash_seq.sv
// tb_zapper_flash_seq: randomized self-checking bench for zapper_flash_seq.
//
// Each frame is a frame_start cycle, a burst of pixels scattered around the target
// boxes, three fixed probe pixels and two blanking cycles. The reference model keeps
// the pending flash sequence as a queue of frame kinds (-1 black, k target k). It
// predicts every registered output one clock after the inputs that produced it.
module tb_zapper_flash_seq;
  localparam int NT   = 2;
  localparam int BW   = 32;
  localparam int BH   = 32;
  localparam int RW   = 6;
  localparam int NPIX = 40;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_start;
  logic               valid;
  logic [9:0]         col;
  logic [9:0]         row;
  logic [RW-1:0]      bg_rgb;
  logic               trigger;
  logic               light;
  logic [NT-1:0]      target_en;
  logic [10*NT-1:0]   target_x;
  logic [10*NT-1:0]   target_y;
  logic [RW-1:0]      rgb;
  logic               busy;
  logic               hit_valid;
  logic               hit;
  logic [1:0]         hit_idx;

  zapper_flash_seq #(
    .N_TARGETS(NT),
    .BOX_W    (BW),
    .BOX_H    (BH),
    .RGB_W    (RW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .valid      (valid),
    .col        (col),
    .row        (row),
    .bg_rgb     (bg_rgb),
    .trigger    (trigger),
    .light      (light),
    .target_en  (target_en),
    .target_x   (target_x),
    .target_y   (target_y),
    .rgb        (rgb),
    .busy       (busy),
    .hit_valid  (hit_valid),
    .hit        (hit),
    .hit_idx    (hit_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scenario setup
  int        tx[NT];
  int        ty[NT];
  logic [NT-1:0] en;
  int        lmode;   // 0 dark, 1 always lit, 2 random light, 3 gun aimed at target 'aim'
  int        aim;
  bit        trig_lvl;

  // Reference model
  int        m_mode;  // 0 idle, 1 sequence running, 2 holding result
  int        seq[$];
  bit        m_pending, m_prev, m_cheat, m_hit;
  int        m_idx;
  bit        e_hit;
  int        e_idx;

  // Observation bookkeeping
  int            fs_cnt, hv_cnt, hv_fs;
  logic          last_hit;
  logic [1:0]    last_idx;
  logic [RW-1:0] last_rgb;
  logic [RW-1:0] pa[16];
  logic [RW-1:0] pb[16];
  logic [RW-1:0] pc[16];

  function automatic bit in_box(int k, int c, int r);
    return c >= tx[k] && c < tx[k] + BW && r >= ty[k] && r < ty[k] + BH;
  endfunction

  function automatic logic [RW-1:0] model_rgb(bit vld, int c, int r, logic [RW-1:0] bg);
    if (!vld) return '0;
    if (m_mode == 1) begin
      if (seq[0] < 0) return '0;
      return in_box(seq[0], c, r) ? {RW{1'b1}} : '0;
    end
    return bg;
  endfunction

  function automatic bit light_for(int c, int r);
    case (lmode)
      1:       return 1'b1;
      2:       return $urandom_range(0, 7) == 0;
      3:       return m_mode == 1 && seq[0] == aim && in_box(aim, c, r);
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input bit fs, input bit vld, input int c, input int r);
    logic [RW-1:0] bg, e_rgb;
    bit lt, rise, e_hv;
    bg    = RW'($urandom);
    lt    = light_for(c, r);
    e_rgb = model_rgb(vld, c, r, bg);
    e_hv  = 1'b0;
    rise  = trig_lvl && !m_prev;
    if (m_mode == 0) begin
      if (fs && (m_pending || rise)) begin
        seq.delete();
        seq.push_back(-1);
        for (int k = 0; k < NT; k++) if (en[k]) seq.push_back(k);
        m_mode = 1; m_pending = 0; m_cheat = 0; m_hit = 0; m_idx = 0;
      end else if (rise) begin
        m_pending = 1;
      end
    end else if (m_mode == 1) begin
      if (vld && lt) begin
        if (seq[0] < 0) m_cheat = 1;
        else if (!m_hit) begin m_hit = 1; m_idx = seq[0]; end
      end
      if (fs) begin
        void'(seq.pop_front());
        if (seq.size() == 0) begin
          e_hv   = 1'b1;
          e_hit  = m_hit && !m_cheat;
          e_idx  = e_hit ? m_idx : 0;
          m_mode = 2;
        end
      end
    end else if (fs && !trig_lvl) begin
      m_mode = 0;
    end
    m_prev = trig_lvl;

    frame_start = fs;
    valid       = vld;
    col         = 10'(c);
    row         = 10'(r);
    bg_rgb      = bg;
    trigger     = trig_lvl;
    light       = lt;
    target_en   = en;
    for (int k = 0; k < NT; k++) begin
      target_x[10*k +: 10] = 10'(tx[k]);
      target_y[10*k +: 10] = 10'(ty[k]);
    end
    @(posedge clk);
    #1;
    if (fs) fs_cnt++;
    check("rgb", 32'(rgb), 32'(e_rgb));
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("hit_valid", 32'(hit_valid), 32'(e_hv));
    check("hit", 32'(hit), 32'(e_hit));
    check("hit_idx", 32'(hit_idx), 32'(e_idx));
    last_rgb = rgb;
    if (hit_valid) begin
      hv_cnt++;
      hv_fs    = fs_cnt;
      last_hit = hit;
      last_idx = hit_idx;
    end
  endtask

  task automatic pix();
    int k, c, r;
    if ($urandom_range(0, 3) == 0) begin
      c = int'($urandom_range(0, 1023));
      r = int'($urandom_range(0, 1023));
    end else begin
      k = int'($urandom_range(0, NT - 1));
      c = (tx[k] + int'($urandom_range(0, BW + 7)) - 4) & 1023;
      r = (ty[k] + int'($urandom_range(0, BH + 7)) - 4) & 1023;
    end
    step(1'b0, 1'b1, c, r);
  endtask

  task automatic frame();
    bit v0;
    int f;
    v0 = (lmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    step(1'b1, v0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    f = (fs_cnt < 16) ? fs_cnt : 15;
    for (int p = 0; p < NPIX; p++) pix();
    step(1'b0, 1'b1, 100, 50);
    pa[f] = last_rgb;
    step(1'b0, 1'b1, 1015, (ty[0] + 1) & 1023);
    pb[f] = last_rgb;
    step(1'b0, 1'b1, 5, (ty[0] + 1) & 1023);
    pc[f] = last_rgb;
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1015, (ty[0] + 1) & 1023);
  endtask

  // Trigger rises mid-frame in idle; hold = number of frames it stays pressed
  // (0: released again before the first frame_start).
  task automatic run_seq(input logic [NT-1:0] e, input int mode, input int hold, input int nfr);
    en = e; lmode = mode;
    fs_cnt = 0; hv_cnt = 0; hv_fs = -1;
    trig_lvl = 1'b0;
    repeat (3) pix();
    trig_lvl = 1'b1;
    pix();
    if (hold == 0) trig_lvl = 1'b0;
    pix();
    for (int f = 1; f <= nfr; f++) begin
      if (f > hold) trig_lvl = 1'b0;
      frame();
    end
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hit_valid", 32'(hit_valid), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_hit_idx", 32'(hit_idx), 32'd0);
    m_mode = 0; seq.delete(); m_pending = 0; m_prev = 0; m_cheat = 0; m_hit = 0; m_idx = 0;
    e_hit = 0; e_idx = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int pop, hold, nfr;
    rst = 1'b0; frame_start = 1'b0; valid = 1'b0; col = '0; row = '0; bg_rgb = '0;
    trigger = 1'b0; light = 1'b0; target_en = '0; target_x = '0; target_y = '0;
    trig_lvl = 1'b0; en = '0; lmode = 0; aim = 0;
    m_mode = 0; m_pending = 0; m_prev = 0; m_cheat = 0; m_hit = 0; m_idx = 0;
    e_hit = 0; e_idx = 0; fs_cnt = 0; hv_cnt = 0; hv_fs = -1;
    last_hit = 1'b0; last_idx = 2'd0; last_rgb = '0;
    tx[0] = 300; ty[0] = 200; tx[1] = 100; ty[1] = 50;

    #1 rst = 1'b1;
    #1;
    check("reset_rgb", 32'(rgb), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hit_valid", 32'(hit_valid), 32'd0);
    check("reset_hit", 32'(hit), 32'd0);
    check("reset_hit_idx", 32'(hit_idx), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic hit on target 1
    aim = 1;
    run_seq(2'b11, 3, 0, 5);
    check("basic_hv_cnt", 32'(hv_cnt), 32'd1);
    check("basic_hv_fs", 32'(hv_fs), 32'd4);
    check("basic_hit", 32'(last_hit), 32'd1);
    check("basic_idx", 32'(last_idx), 32'd1);
    check("basic_probe_f1", 32'(pa[1]), 32'h00);
    check("basic_probe_f2", 32'(pa[2]), 32'h00);
    check("basic_probe_f3", 32'(pa[3]), 32'h3f);

    // Cheat: light everywhere
    run_seq(2'b11, 1, 0, 5);
    check("cheat_hv_cnt", 32'(hv_cnt), 32'd1);
    check("cheat_hv_fs", 32'(hv_fs), 32'd4);
    check("cheat_hit", 32'(last_hit), 32'd0);
    check("cheat_idx", 32'(last_idx), 32'd0);

    // Target 0 disabled
    run_seq(2'b10, 3, 0, 4);
    check("skip_hv_fs", 32'(hv_fs), 32'd3);
    check("skip_hit", 32'(last_hit), 32'd1);
    check("skip_idx", 32'(last_idx), 32'd1);

    // No targets enabled
    run_seq(2'b00, 3, 0, 3);
    check("none_hv_fs", 32'(hv_fs), 32'd2);
    check("none_hit", 32'(last_hit), 32'd0);

    // Trigger held for 6 frames, then a press while still holding is ignored
    aim = 0;
    run_seq(2'b11, 3, 6, 6);
    check("held_hv_cnt", 32'(hv_cnt), 32'd1);
    check("held_busy", 32'(busy), 32'd1);
    run_seq(2'b11, 3, 0, 5);
    check("held_refire", 32'(hv_cnt), 32'd0);
    run_seq(2'b11, 3, 0, 5);
    check("second_hv_cnt", 32'(hv_cnt), 32'd1);
    check("second_idx", 32'(last_idx), 32'd0);

    // Box at the right screen edge
    tx[0] = 1010; ty[0] = 100;
    run_seq(2'b01, 0, 0, 4);
    check("edge_in_f2", 32'(pb[2]), 32'h3f);
    check("edge_wrap_f2", 32'(pc[2]), 32'h00);
    check("edge_black_f1", 32'(pb[1]), 32'h00);

    // Reset in the middle of a target frame
    tx[0] = 300; ty[0] = 200;
    en = 2'b11; lmode = 3; aim = 0; fs_cnt = 0; hv_cnt = 0;
    trig_lvl = 1'b1; pix();
    trig_lvl = 1'b0; pix();
    frame();
    frame();
    repeat (5) pix();
    async_reset();
    hv_cnt = 0;
    repeat (4) frame();
    check("rst_no_result", 32'(hv_cnt), 32'd0);
    check("rst_idle", 32'(busy), 32'd0);

    // Random scenarios
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < NT; k++) begin
        tx[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023))
                                            : int'($urandom_range(0, 1023));
        ty[k] = int'($urandom_range(0, 500));
      end
      aim  = int'($urandom_range(0, NT - 1));
      en   = NT'($urandom);
      pop  = $countones(en);
      hold = int'($urandom_range(0, 6));
      nfr  = ((2 + pop > hold) ? 2 + pop : hold) + 2;
      run_seq(en, int'($urandom_range(0, 3)), hold, nfr);
      check("rand_hv_cnt", 32'(hv_cnt), 32'd1);
      check("rand_hv_fs", 32'(hv_fs), 32'(2 + pop));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
